// File: rtl/muxn_pkg.sv
`default_nettype none
// muxn_pkg -- shared mode encoding and select-width helper for muxn_stream. Rev 1.0
package muxn_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/muxn_stream_rr_arbiter.sv
`default_nettype none
// rr_arbiter -- fair round-robin grant over NUM_CH requesters, pointer moves on accept. Rev 1.0
module rr_arbiter
   import muxn_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int SEL_W  = sel_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [SEL_W-1:0]  grant_idx,
   output logic              grant_vld
);

   logic [SEL_W-1:0] r_ptr;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      int w_idx;
      w_idx     = 0;
      grant_idx = '0;
      grant_vld = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_CH;
         if (!grant_vld && req[w_idx]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(w_idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= SEL_W'(NUM_CH - 1);
      end else if (advance) begin
         r_ptr <= grant_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/muxn_stream.sv
`default_nettype none
// muxn_stream -- N:1 valid/ready stream mux (select or round-robin) with registered output. Rev 1.0
module muxn_stream
   import muxn_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int DATA_W = 8,
   parameter  int MODE   = 0,
   parameter  int CNT_W  = 16,
   localparam int SEL_W  = sel_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sel_err,
   output logic [CNT_W-1:0]         xfer_cnt
);

   logic [SEL_W-1:0]  w_grant;
   logic              w_grant_vld;
   logic              w_sel_bad;
   logic              w_load_en;
   logic              w_accept;

   logic [DATA_W-1:0] r_data;
   logic [SEL_W-1:0]  r_ch;
   logic              r_valid;
   logic              r_sel_err;
   logic [CNT_W-1:0]  r_cnt;

   assign w_load_en = !r_valid || out_ready;
   assign w_accept  = w_load_en && w_grant_vld;

   generate
      if (MODE == int'(MODE_RR)) begin : g_rr
         logic w_unused_sel;
         assign w_unused_sel = ^sel;
         assign w_sel_bad    = 1'b0;

         rr_arbiter #(
            .NUM_CH (NUM_CH)
         ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (in_valid),
            .advance   (w_accept),
            .grant_idx (w_grant),
            .grant_vld (w_grant_vld)
         );
      end else begin : g_sel
         logic w_sel_ok;
         // Out-of-range selects only exist when NUM_CH is not a power of two.
         if (NUM_CH == (1 << SEL_W)) begin : g_full
            assign w_sel_ok = 1'b1;
         end else begin : g_part
            assign w_sel_ok = (32'(sel) < NUM_CH);
         end
         assign w_grant     = sel;
         assign w_grant_vld = w_sel_ok && in_valid[sel];
         assign w_sel_bad   = !w_sel_ok;
      end
   endgenerate

   always_comb begin
      in_ready = '0;
      if (w_accept) begin
         in_ready[w_grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_ch      <= '0;
         r_sel_err <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_load_en) begin
            r_valid <= w_grant_vld;
         end
         if (w_accept) begin
            r_data <= in_data[int'(w_grant)*DATA_W +: DATA_W];
            r_ch   <= w_grant;
         end
         if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_sel_bad) begin
            r_sel_err <= 1'b1;
         end
      end
   end

   assign out_data  = r_data;
   assign out_ch    = r_ch;
   assign out_valid = r_valid;
   assign sel_err   = r_sel_err;
   assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_muxn_stream.sv
`timescale 1ns/1ps
`default_nettype none
// tb_muxn_stream -- self-checking bench: SEL table, SEL error/saturation, RR scoreboard. Rev 1.0
module tb_muxn_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // SEL mode, 4 channels
   logic [31:0] s4_in_data;
   logic [3:0]  s4_in_valid, s4_in_ready;
   logic [1:0]  s4_sel, s4_out_ch;
   logic [7:0]  s4_out_data;
   logic        s4_out_valid, s4_out_ready, s4_sel_err;
   logic [15:0] s4_cnt;

   muxn_stream #(.NUM_CH(4), .DATA_W(8), .MODE(0), .CNT_W(16)) u_sel4 (
      .clk(clk), .rst(rst), .in_data(s4_in_data), .in_valid(s4_in_valid),
      .in_ready(s4_in_ready), .sel(s4_sel), .out_data(s4_out_data), .out_ch(s4_out_ch),
      .out_valid(s4_out_valid), .out_ready(s4_out_ready), .sel_err(s4_sel_err),
      .xfer_cnt(s4_cnt));

   // SEL mode, 5 channels (out-of-range select possible), 4-bit counter
   logic [39:0] s5_in_data;
   logic [4:0]  s5_in_valid, s5_in_ready;
   logic [2:0]  s5_sel, s5_out_ch;
   logic [7:0]  s5_out_data;
   logic        s5_out_valid, s5_out_ready, s5_sel_err;
   logic [3:0]  s5_cnt;

   muxn_stream #(.NUM_CH(5), .DATA_W(8), .MODE(0), .CNT_W(4)) u_sel5 (
      .clk(clk), .rst(rst), .in_data(s5_in_data), .in_valid(s5_in_valid),
      .in_ready(s5_in_ready), .sel(s5_sel), .out_data(s5_out_data), .out_ch(s5_out_ch),
      .out_valid(s5_out_valid), .out_ready(s5_out_ready), .sel_err(s5_sel_err),
      .xfer_cnt(s5_cnt));

   // RR mode, 4 channels
   logic [31:0] rr_in_data;
   logic [3:0]  rr_in_valid, rr_in_ready;
   logic [1:0]  rr_sel, rr_out_ch;
   logic [7:0]  rr_out_data;
   logic        rr_out_valid, rr_out_ready, rr_sel_err;
   logic [15:0] rr_cnt;

   muxn_stream #(.NUM_CH(4), .DATA_W(8), .MODE(1), .CNT_W(16)) u_rr4 (
      .clk(clk), .rst(rst), .in_data(rr_in_data), .in_valid(rr_in_valid),
      .in_ready(rr_in_ready), .sel(rr_sel), .out_data(rr_out_data), .out_ch(rr_out_ch),
      .out_valid(rr_out_valid), .out_ready(rr_out_ready), .sel_err(rr_sel_err),
      .xfer_cnt(rr_cnt));

   typedef struct {
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_ch;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl[6];

   typedef struct {
      logic [7:0] d;
      logic [1:0] ch;
   } beat_t;

   beat_t sbq[$];

   function automatic logic [31:0] rr_pack(input int tag);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = {tag[3:0], i[3:0]};
      return v;
   endfunction

   // Drive one RR cycle; exp_ch < 0 means no channel should be accepted.
   task automatic rr_cycle(input logic [3:0] vld, input logic ordy, input int tag, input int exp_ch);
      logic [3:0] er;
      beat_t      b;
      rr_in_valid  = vld;
      rr_out_ready = ordy;
      rr_in_data   = rr_pack(tag);
      #1;
      er = (exp_ch < 0) ? 4'b0000 : 4'(1 << exp_ch);
      chk("rr_in_ready", 64'(rr_in_ready), 64'(er));
      if (exp_ch >= 0) begin
         b.d  = {tag[3:0], exp_ch[3:0]};
         b.ch = exp_ch[1:0];
         sbq.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   // Consumer side: a beat present with out_ready high is taken at the next edge.
   always @(negedge clk) begin
      beat_t b;
      if (!rst && rr_out_valid && rr_out_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rr_unexpected_beat actual_ch=%0d actual_data=0x%0h expected=none",
                     rr_out_ch, rr_out_data);
         end else begin
            b = sbq.pop_front();
            chk("rr_out_ch", 64'(rr_out_ch), 64'(b.ch));
            chk("rr_out_data", 64'(rr_out_data), 64'(b.d));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_cnt;
      rst = 1'b1;
      s4_in_data = '0; s4_in_valid = '0; s4_sel = '0; s4_out_ready = 1'b0;
      s5_in_data = '0; s5_in_valid = '0; s5_sel = '0; s5_out_ready = 1'b0;
      rr_in_data = '0; rr_in_valid = '0; rr_sel = '0; rr_out_ready = 1'b0;

      tbl[0] = '{2'd2, 4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 16'd1};
      tbl[1] = '{2'd1, 4'b0010, 32'h0000_3C00, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd1, 16'd2};
      tbl[2] = '{2'd0, 4'b0010, 32'h0000_3C00, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd1, 16'd2};
      tbl[3] = '{2'd3, 4'b1111, 32'h7766_5544, 1'b0, 4'b1000, 1'b1, 8'h77, 2'd3, 16'd3};
      tbl[4] = '{2'd0, 4'b1111, 32'h7766_5544, 1'b0, 4'b0000, 1'b1, 8'h77, 2'd3, 16'd3};
      tbl[5] = '{2'd0, 4'b1111, 32'h7766_5544, 1'b1, 4'b0001, 1'b1, 8'h44, 2'd0, 16'd4};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_s4_valid", 64'(s4_out_valid), 64'd0);
      chk("rst_s4_data",  64'(s4_out_data),  64'd0);
      chk("rst_s4_ch",    64'(s4_out_ch),    64'd0);
      chk("rst_s4_cnt",   64'(s4_cnt),       64'd0);
      chk("rst_s4_err",   64'(s4_sel_err),   64'd0);
      chk("rst_rr_valid", 64'(rr_out_valid), 64'd0);
      chk("rst_rr_cnt",   64'(rr_cnt),       64'd0);
      chk("rst_s5_err",   64'(s5_sel_err),   64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // SEL mode table
      for (int i = 0; i < 6; i++) begin
         s4_sel = tbl[i].sel; s4_in_valid = tbl[i].vld;
         s4_in_data = tbl[i].data; s4_out_ready = tbl[i].ordy;
         #1;
         chk("s4_in_ready", 64'(s4_in_ready), 64'(tbl[i].exp_rdy));
         @(posedge clk);
         #1;
         chk("s4_out_valid", 64'(s4_out_valid), 64'(tbl[i].exp_ov));
         chk("s4_out_data",  64'(s4_out_data),  64'(tbl[i].exp_od));
         chk("s4_out_ch",    64'(s4_out_ch),    64'(tbl[i].exp_ch));
         chk("s4_xfer_cnt",  64'(s4_cnt),       64'(tbl[i].exp_cnt));
      end
      chk("s4_sel_err", 64'(s4_sel_err), 64'd0);
      s4_in_valid = '0;

      // Out-of-range select on a 5-channel mux
      s5_sel = 3'd1; s5_in_valid = 5'b00010; s5_in_data = 40'h00_0000_5A00; s5_out_ready = 1'b1;
      #1;
      chk("s5_in_ready_ok", 64'(s5_in_ready), 64'b00010);
      @(posedge clk); #1;
      chk("s5_valid_ok", 64'(s5_out_valid), 64'd1);
      chk("s5_data_ok",  64'(s5_out_data),  64'h5A);
      chk("s5_err_pre",  64'(s5_sel_err),   64'd0);
      s5_sel = 3'd5; s5_in_valid = 5'b11111;
      #1;
      chk("s5_in_ready_bad", 64'(s5_in_ready), 64'd0);
      @(posedge clk); #1;
      chk("s5_valid_bad", 64'(s5_out_valid), 64'd0);
      chk("s5_err_set",   64'(s5_sel_err),   64'd1);
      s5_sel = 3'd0; s5_in_data = 40'h55_4433_2211;
      #1;
      chk("s5_in_ready_sel0", 64'(s5_in_ready), 64'b00001);
      @(posedge clk); #1;
      chk("s5_err_sticky", 64'(s5_sel_err),   64'd1);
      chk("s5_valid_sel0", 64'(s5_out_valid), 64'd1);
      chk("s5_data_sel0",  64'(s5_out_data),  64'h11);
      chk("s5_cnt_sel0",   64'(s5_cnt),       64'd2);
      exp_cnt = 2;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
         chk("s5_cnt_sat", 64'(s5_cnt), 64'(exp_cnt));
      end
      s5_in_valid = '0;

      // RR: full rotation
      for (int k = 0; k < 8; k++) rr_cycle(4'hF, 1'b1, k, k % 4);
      chk("rr_cnt_8", 64'(rr_cnt), 64'd8);

      // RR: backpressure holds output and pointer
      rr_cycle(4'hF, 1'b1, 8, 0);
      for (int s = 0; s < 3; s++) begin
         rr_cycle(4'hF, 1'b0, 9 + s, -1);
         chk("rr_hold_valid", 64'(rr_out_valid), 64'd1);
         chk("rr_hold_ch",    64'(rr_out_ch),    64'd0);
         chk("rr_hold_data",  64'(rr_out_data),  64'h80);
      end
      rr_cycle(4'hF, 1'b1, 12, 1);
      rr_cycle(4'hF, 1'b1, 13, 2);
      chk("rr_cnt_11", 64'(rr_cnt), 64'd11);
      rr_cycle(4'hF, 1'b1, 14, 3);
      rr_cycle(4'hF, 1'b1, 15, 0);
      rr_cycle(4'h0, 1'b0, 0, -1);
      chk("rr_pre_rst_valid", 64'(rr_out_valid), 64'd1);

      // Reset mid-stream: in-flight beat discarded
      #2;
      rst = 1'b1;
      #1;
      chk("rr_midrst_valid", 64'(rr_out_valid), 64'd0);
      chk("rr_midrst_cnt",   64'(rr_cnt),       64'd0);
      chk("s5_midrst_err",   64'(s5_sel_err),   64'd0);
      sbq.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      rr_cycle(4'hF, 1'b1, 1, 0);
      rr_cycle(4'h0, 1'b1, 0, -1);
      rr_cycle(4'h0, 1'b1, 0, -1);
      chk("rr_post_rst_cnt", 64'(rr_cnt), 64'd1);
      chk("rr_sb_empty", 64'(sbq.size()), 64'd0);
      chk("rr_sel_err", 64'(rr_sel_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
